// File: rtl/dic_time_uart_tx_if.sv
// Bundle of request, snapshot data and serial status signals for the clock's
// console transmitter. The master drives the request and digits; the slave
// (the transmitter) drives the serial line and status pulses.
interface dic_time_uart_tx_if;
  logic       send;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       alarm_ena;
  logic       uart_tx;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output send, min_tens, min_ones, sec_tens, sec_ones, alarm_ena,
    input  uart_tx, busy, done, overrun
  );

  modport slave (
    input  send, min_tens, min_ones, sec_tens, sec_ones, alarm_ena,
    output uart_tx, busy, done, overrun
  );
endinterface

// File: rtl/dic_time_uart_tx.sv
// Console transmitter for the clock: on each send request it snapshots the
// time digits and alarm flag, then shifts out the 7-character frame
// "MT MO : ST SO A CR" as 8N1 serial data, LSB first.
module dic_time_uart_tx #(
  parameter int unsigned BAUD_DIV = 104
) (
  input logic             clk,
  input logic             rst,
  dic_time_uart_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} TxState;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  TxState      state;
  logic [15:0] baudCnt;
  logic [2:0]  bitCnt;
  logic [2:0]  charIdx;
  logic [7:0]  frameBuf [0:6];
  logic        txReg;
  logic        busyReg;
  logic        doneReg;
  logic        overrunReg;
  logic        baudWrap;
  logic        accept;

  // A digit outside 0..9 is shown as '?' so bad BCD is visible on the terminal.
  function automatic logic [7:0] digitChar(input logic [3:0] d);
    return (d <= 4'd9) ? {4'h3, d} : 8'h3F;
  endfunction

  assign baudWrap = (baudCnt == BAUD_LAST);
  assign accept   = bus.send && (state == IDLE);

  // Snapshot the whole frame at acceptance so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      frameBuf[0] <= digitChar(bus.min_tens);
      frameBuf[1] <= digitChar(bus.min_ones);
      frameBuf[2] <= 8'h3A;
      frameBuf[3] <= digitChar(bus.sec_tens);
      frameBuf[4] <= digitChar(bus.sec_ones);
      frameBuf[5] <= bus.alarm_ena ? 8'h40 : 8'h20;
      frameBuf[6] <= 8'h0D;
    end
  end

  // Framing FSM: every bit lasts one full baud-counter wrap, characters follow
  // each other with no idle gap, and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baudCnt    <= '0;
      bitCnt     <= '0;
      charIdx    <= '0;
      txReg      <= 1'b1;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      overrunReg <= 1'b0;
    end else begin
      doneReg    <= 1'b0;
      overrunReg <= bus.send && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.send) begin
            state   <= START;
            baudCnt <= '0;
            bitCnt  <= '0;
            charIdx <= '0;
            txReg   <= 1'b0;
            busyReg <= 1'b1;
          end
        end
        START: begin
          if (baudWrap) begin
            baudCnt <= '0;
            bitCnt  <= '0;
            state   <= DATA;
            txReg   <= frameBuf[charIdx][0];
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        DATA: begin
          if (baudWrap) begin
            baudCnt <= '0;
            if (bitCnt == 3'd7) begin
              state <= STOP;
              txReg <= 1'b1;
            end else begin
              bitCnt <= bitCnt + 3'd1;
              txReg  <= frameBuf[charIdx][bitCnt + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        STOP: begin
          if (baudWrap) begin
            baudCnt <= '0;
            if (charIdx == 3'd6) begin
              state   <= IDLE;
              charIdx <= '0;
              busyReg <= 1'b0;
              doneReg <= 1'b1;
            end else begin
              charIdx <= charIdx + 3'd1;
              state   <= START;
              txReg   <= 1'b0;
            end
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.uart_tx = txReg;
  assign bus.busy    = busyReg;
  assign bus.done    = doneReg;
  assign bus.overrun = overrunReg;

endmodule
